// File: rtl/gate_sweep_capture.sv
// Truth-table sweeper: steps every input vector, lets it settle, captures the response.
// Optional GATE_SWEEP_CHECK_EN adds an expected-table compare with a sticky first-mismatch index.
module gate_sweep_capture #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [N_OUT-1:0]             i_resp,
`ifdef GATE_SWEEP_CHECK_EN
    input  logic [N_OUT*(2**N_IN)-1:0]   i_exp_tt,
    output logic                         o_mismatch,
    output logic [N_IN-1:0]              o_err_idx,
`endif
    output logic [N_IN-1:0]              o_stim,
    output logic [N_OUT*(2**N_IN)-1:0]   o_tt,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int unsigned NVec = 2 ** N_IN;
    localparam int unsigned TtW  = N_OUT * NVec;
    // One spare bit so N_IN=8 never wraps; termination is by compare.
    localparam int unsigned IdxW = $clog2(NVec) + 1;
    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NVec - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCapture,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [IdxW-1:0]   r_idx;
    logic [IdxW-1:0]   w_idx_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic [N_IN-1:0]   r_stim;
    logic [N_IN-1:0]   w_stim_d;
    logic [TtW-1:0]    r_tt;
    logic [TtW-1:0]    w_tt_d;
    logic              r_busy;
    logic              w_busy_d;
    logic              r_done;
    logic              w_done_d;
    logic              w_start_sweep;
    logic              w_capture;

`ifdef GATE_SWEEP_CHECK_EN
    logic              r_mismatch;
    logic              w_mismatch_d;
    logic [N_IN-1:0]   r_err_idx;
    logic [N_IN-1:0]   w_err_idx_d;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_idx_d       = r_idx;
        w_cnt_d       = r_cnt;
        w_stim_d      = r_stim;
        w_tt_d        = r_tt;
        w_start_sweep = 1'b0;
        w_capture     = 1'b0;

        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_start_sweep = 1'b1;
                    w_state_d     = StDrive;
                    w_idx_d       = '0;
                    w_cnt_d       = '0;
                    w_stim_d      = '0;
                    w_tt_d        = '0;
                end
            end
            StDrive: begin
                if (r_cnt == CntLast) begin
                    w_state_d = StCapture;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StCapture: begin
                w_capture                      = 1'b1;
                w_tt_d[r_idx*N_OUT +: N_OUT]   = i_resp;
                if (r_idx == LastIdx) begin
                    w_state_d = StDone;
                end else begin
                    w_idx_d   = r_idx + 1'b1;
                    w_stim_d  = N_IN'(r_idx + 1'b1);
                    w_state_d = StDrive;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_busy_d = (w_state_d == StDrive) || (w_state_d == StCapture);
        w_done_d = (w_state_d == StDone);
    end

`ifdef GATE_SWEEP_CHECK_EN
    always_comb begin
        w_mismatch_d = r_mismatch;
        w_err_idx_d  = r_err_idx;
        if (w_start_sweep) begin
            w_mismatch_d = 1'b0;
            w_err_idx_d  = '0;
        end else if (w_capture && !r_mismatch &&
                     (i_resp != i_exp_tt[r_idx*N_OUT +: N_OUT])) begin
            w_mismatch_d = 1'b1;
            w_err_idx_d  = N_IN'(r_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mismatch <= 1'b0;
            r_err_idx  <= '0;
        end else begin
            r_mismatch <= w_mismatch_d;
            r_err_idx  <= w_err_idx_d;
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_err_idx  = r_err_idx;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_stim  <= '0;
            r_tt    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
            r_stim  <= w_stim_d;
            r_tt    <= w_tt_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    assign o_stim = r_stim;
    assign o_tt   = r_tt;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_gate_sweep_capture.sv
// Bench for gate_sweep_capture: random truth tables vs. a table-level model, timing and boundaries.
// Compare-port scenarios are compiled when GATE_SWEEP_CHECK_EN is defined.
module tb_gate_sweep_capture;

    localparam int unsigned SweepCycles  = 4 * 3;
    localparam int unsigned SweepCycles2 = 8 * 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start2;
    logic [1:0] stim;
    logic [7:0] tt;
    logic       busy;
    logic       done;
    logic [1:0] resp;
    logic [2:0] stim2;
    logic [7:0] tt2;
    logic       busy2;
    logic       done2;
    logic       resp2;
    logic [1:0] fn_tbl [4];
    logic       glitch_en;
    logic [1:0] glitch_val;
    int         checks   = 0;
    int         failures = 0;

`ifdef GATE_SWEEP_CHECK_EN
    logic [7:0] exp_tt;
    logic       mismatch;
    logic [1:0] err_idx;
    logic [2:0] exp_tt2;
    logic       mismatch2;
    logic [2:0] err_idx2;
    logic [7:0] exp_tt2_full;
    assign exp_tt2_full = 8'h96;
`endif

    always #5 clk = ~clk;

    always_comb resp = glitch_en ? glitch_val : fn_tbl[stim];
    assign resp2 = ^stim2;

    gate_sweep_capture #(.N_IN(2), .N_OUT(2), .SETTLE(2)) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_resp    (resp),
`ifdef GATE_SWEEP_CHECK_EN
        .i_exp_tt  (exp_tt),
        .o_mismatch(mismatch),
        .o_err_idx (err_idx),
`endif
        .o_stim    (stim),
        .o_tt      (tt),
        .o_busy    (busy),
        .o_done    (done)
    );

    gate_sweep_capture #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_dut2 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start2),
        .i_resp    (resp2),
`ifdef GATE_SWEEP_CHECK_EN
        .i_exp_tt  (exp_tt2_full),
        .o_mismatch(mismatch2),
        .o_err_idx (err_idx2),
`endif
        .o_stim    (stim2),
        .o_tt      (tt2),
        .o_busy    (busy2),
        .o_done    (done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected table: entry v of the table is whatever the gate function gives for v.
    function automatic logic [7:0] model_tt();
        logic [7:0] m;
        m = '0;
        for (int v = 0; v < 4; v++) m[v*2 +: 2] = fn_tbl[v];
        return m;
    endfunction

    task automatic set_nornand();
        logic [1:0] vv;
        for (int v = 0; v < 4; v++) begin
            vv        = 2'(v);
            fn_tbl[v] = {~|vv, ~&vv};
        end
    endtask

    task automatic set_random_tbl();
        for (int v = 0; v < 4; v++) fn_tbl[v] = 2'($urandom_range(0, 3));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({stim, tt, busy, done} !== 12'h0) begin
            failures++;
            $display("FAIL reset_state: stim=%0d tt=%h busy=%b done=%b required all zero",
                     stim, tt, busy, done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        set_nornand();
        exp = model_tt();
        pulse_start();
        for (int k = 0; k < int'(SweepCycles); k++) begin
            checks++;
            if (stim !== 2'(k / 3) || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL sweep_cycle%0d: stim=%0d busy=%b done=%b required stim=%0d busy=1 done=0",
                         k, stim, busy, done, k / 3);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_done_time: done=%b busy=%b required done=1 busy=0", done, busy);
        end
        checks++;
        if (tt !== exp || tt !== 8'h17) begin
            failures++;
            $display("FAIL sweep_tt: tt=%h required %h", tt, exp);
        end
        checks++;
        if (stim !== 2'd3) begin
            failures++;
            $display("FAIL sweep_last_stim: stim=%0d required 3", stim);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (done !== 1'b1 || tt !== exp) begin
            failures++;
            $display("FAIL done_hold: done=%b tt=%h required 1/%h", done, tt, exp);
        end
    endtask

    task automatic test_random_tables();
        int         n;
        logic [7:0] exp;
        for (int it = 0; it < 6; it++) begin
            set_random_tbl();
            exp = model_tt();
            pulse_start();
            wait_done(n);
            checks++;
            if (n != int'(SweepCycles) || tt !== exp) begin
                failures++;
                $display("FAIL random_tbl%0d: cycles=%0d tt=%h required cycles=%0d tt=%h",
                         it, n, tt, SweepCycles, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int         n;
        logic [7:0] exp;
        set_random_tbl();
        exp   = model_tt();
        start = 1'b1;
        tick();
        wait_done(n);
        checks++;
        if (n != int'(SweepCycles) || tt !== exp) begin
            failures++;
            $display("FAIL held_start_sweep: cycles=%0d tt=%h required cycles=%0d tt=%h",
                     n, tt, SweepCycles, exp);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || stim !== 2'd0 || tt !== 8'h00) begin
            failures++;
            $display("FAIL resweep_entry: busy=%b done=%b stim=%0d tt=%h required 1/0/0/00",
                     busy, done, stim, tt);
        end
        start = 1'b0;
        set_random_tbl();
        exp = model_tt();
        wait_done(n);
        checks++;
        if (n != int'(SweepCycles) || tt !== exp) begin
            failures++;
            $display("FAIL resweep: cycles=%0d tt=%h required cycles=%0d tt=%h",
                     n, tt, SweepCycles, exp);
        end
    endtask

    task automatic test_reset_mid();
        int         n;
        logic [7:0] exp;
        set_nornand();
        exp = model_tt();
        pulse_start();
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({stim, tt, busy, done} !== 12'h0) begin
            failures++;
            $display("FAIL mid_reset: stim=%0d tt=%h busy=%b done=%b required all zero",
                     stim, tt, busy, done);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b done=%b required 0/0", busy, done);
        end
        pulse_start();
        wait_done(n);
        checks++;
        if (n != int'(SweepCycles) || tt !== exp) begin
            failures++;
            $display("FAIL post_reset_sweep: cycles=%0d tt=%h required cycles=%0d tt=%h",
                     n, tt, SweepCycles, exp);
        end
    endtask

    // Capture happens in the third cycle of each vector; every other cycle carries junk.
    task automatic test_glitch();
        logic [7:0] exp;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) set_nornand(); else set_random_tbl();
            exp       = model_tt();
            glitch_en = 1'b1;
            pulse_start();
            for (int k = 0; k < int'(SweepCycles); k++) begin
                if (k % 3 == 2) glitch_val = fn_tbl[k / 3];
                else            glitch_val = (pass == 0) ? 2'b11 : 2'($urandom);
                tick();
            end
            glitch_en = 1'b0;
            checks++;
            if (done !== 1'b1 || tt !== exp) begin
                failures++;
                $display("FAIL glitch_pass%0d: done=%b tt=%h required 1/%h", pass, done, tt, exp);
            end
        end
    endtask

    task automatic test_small_config();
        int         n;
        logic [7:0] exp;
        logic [2:0] vv;
        exp = '0;
        for (int v = 0; v < 8; v++) begin
            vv     = 3'(v);
            exp[v] = ^vv;
        end
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != int'(SweepCycles2) || tt2 !== exp || tt2 !== 8'h96) begin
            failures++;
            $display("FAIL small_cfg: cycles=%0d tt=%h required cycles=%0d tt=%h",
                     n, tt2, SweepCycles2, exp);
        end
        checks++;
        if (busy2 !== 1'b0 || stim2 !== 3'd7) begin
            failures++;
            $display("FAIL small_cfg_end: busy=%b stim=%0d required 0/7", busy2, stim2);
        end
    endtask

`ifdef GATE_SWEEP_CHECK_EN
    task automatic test_check();
        int n;
        set_nornand();
        exp_tt    = 8'h17;
        fn_tbl[2] = 2'b00;
        pulse_start();
        wait_done(n);
        checks++;
        if (mismatch !== 1'b1 || err_idx !== 2'd2 || tt !== 8'h07) begin
            failures++;
            $display("FAIL check_first: mismatch=%b err_idx=%0d tt=%h required 1/2/07",
                     mismatch, err_idx, tt);
        end
        set_nornand();
        fn_tbl[1] = 2'b10;
        fn_tbl[3] = 2'b01;
        pulse_start();
        checks++;
        if (mismatch !== 1'b0) begin
            failures++;
            $display("FAIL check_clear_on_start: mismatch=%b required 0", mismatch);
        end
        wait_done(n);
        checks++;
        if (mismatch !== 1'b1 || err_idx !== 2'd1) begin
            failures++;
            $display("FAIL check_sticky: mismatch=%b err_idx=%0d required 1/1", mismatch, err_idx);
        end
        set_nornand();
        pulse_start();
        wait_done(n);
        checks++;
        if (mismatch !== 1'b0 || tt !== 8'h17) begin
            failures++;
            $display("FAIL check_good: mismatch=%b tt=%h required 0/17", mismatch, tt);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        start2     = 1'b0;
        glitch_en  = 1'b0;
        glitch_val = 2'b00;
        set_nornand();
`ifdef GATE_SWEEP_CHECK_EN
        exp_tt = 8'h17;
`endif
        test_reset();
        test_sweep();
        test_random_tables();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        test_small_config();
`ifdef GATE_SWEEP_CHECK_EN
        test_check();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
